// File: rtl/pll_reconfig_ctrl_pkg.sv
// Shared types and helpers for the rPLL reconfiguration controller.
package pll_reconfig_ctrl_pkg;

    localparam int unsigned SEL_W = 6;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [2:0] {
        RST_PULSE,
        WAIT_LOCK,
        SETTLE,
        RUN,
        FAIL
    } state_t;

    // Gowin rPLL select ports take 63 - (divide-minus-one).
    function automatic sel_t sel_encode(input sel_t div_m1);
        return sel_t'(6'd63 - div_m1);
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Divider-set offer channel between top-level control and the PLL controller.
interface pll_reconfig_ctrl_if;
    import pll_reconfig_ctrl_pkg::*;

    logic cfg_valid;
    logic cfg_ready;
    sel_t cfg_idiv;
    sel_t cfg_fbdiv;
    sel_t cfg_odsel;

    modport master (
        output cfg_valid,
        output cfg_idiv,
        output cfg_fbdiv,
        output cfg_odsel,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_idiv,
        input  cfg_fbdiv,
        input  cfg_odsel,
        output cfg_ready
    );
endinterface

// File: rtl/pll_reconfig_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (rPLL LOCK).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Capture the async level and re-register it to settle metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL sequencer: reset pulse, lock qualification, divider reconfiguration,
// timeout retry and lock-loss recovery. Runs on the crystal clock.
module pll_reconfig_ctrl
    import pll_reconfig_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned IDIV_DEF      = 4,
    parameter int unsigned FBDIV_DEF     = 36,
    parameter logic [5:0]  ODSEL_DEF     = 6'h3E
) (
    input  logic                clk,
    input  logic                rst,
    pll_reconfig_ctrl_if.slave  cfg,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic [5:0]          pll_idsel,
    output logic [5:0]          pll_fbdsel,
    output logic [5:0]          pll_odsel,
    output logic                clk_ok,
    output logic                busy,
    output logic                err,
    output logic [1:0]          retry_cnt
);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST     = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

    localparam sel_t IDSEL_DEF  = sel_encode(sel_t'(IDIV_DEF));
    localparam sel_t FBDSEL_DEF = sel_encode(sel_t'(FBDIV_DEF));

    state_t        state, state_n;
    logic [RW-1:0] rst_cnt, rst_cnt_n;
    logic [TW-1:0] timer, timer_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic [1:0]    retry_n;
    logic          pll_reset_n, clk_ok_n, err_n, busy_n, ready_n, cfg_ready_q;
    sel_t          idsel_n, fbdsel_n, odsel_n;
    logic          lock, accept;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock)
    );

    assign cfg.cfg_ready = cfg_ready_q;
    assign accept        = cfg.cfg_valid & cfg_ready_q;

    // Next-state, counter and registered-output values for the sequencer.
    always_comb begin
        state_n     = state;
        rst_cnt_n   = rst_cnt;
        timer_n     = timer;
        settle_n    = settle_cnt;
        retry_n     = retry_cnt;
        pll_reset_n = pll_reset;
        clk_ok_n    = clk_ok;
        err_n       = err;
        idsel_n     = pll_idsel;
        fbdsel_n    = pll_fbdsel;
        odsel_n     = pll_odsel;

        case (state)
            RST_PULSE: begin
                pll_reset_n = 1'b1;
                clk_ok_n    = 1'b0;
                if (rst_cnt == RST_LAST) begin
                    state_n     = WAIT_LOCK;
                    pll_reset_n = 1'b0;
                    rst_cnt_n   = '0;
                    timer_n     = '0;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end

            // Timeout spans both states: a settle glitch does not restart the timer.
            WAIT_LOCK, SETTLE: begin
                if (timer == TIMEOUT_LAST) begin
                    pll_reset_n = 1'b1;
                    rst_cnt_n   = '0;
                    settle_n    = '0;
                    if (retry_cnt < RETRY_MAX) begin
                        retry_n = retry_cnt + 1'b1;
                        state_n = RST_PULSE;
                    end else begin
                        state_n = FAIL;
                        err_n   = 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                    if (state == WAIT_LOCK) begin
                        if (lock) begin
                            state_n  = SETTLE;
                            settle_n = '0;
                        end
                    end else if (!lock) begin
                        state_n  = WAIT_LOCK;
                        settle_n = '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state_n  = RUN;
                        clk_ok_n = 1'b1;
                    end else begin
                        settle_n = settle_cnt + 1'b1;
                    end
                end
            end

            RUN: begin
                if (!lock) begin
                    state_n     = RST_PULSE;
                    pll_reset_n = 1'b1;
                    clk_ok_n    = 1'b0;
                    retry_n     = '0;
                    rst_cnt_n   = '0;
                end
            end

            FAIL: begin
                pll_reset_n = 1'b1;
                err_n       = 1'b1;
                clk_ok_n    = 1'b0;
            end

            default: begin
                state_n     = RST_PULSE;
                pll_reset_n = 1'b1;
                rst_cnt_n   = '0;
            end
        endcase

        // A new divider set overrides any concurrent lock-loss decision in RUN.
        if (accept) begin
            state_n     = RST_PULSE;
            pll_reset_n = 1'b1;
            clk_ok_n    = 1'b0;
            err_n       = 1'b0;
            retry_n     = '0;
            rst_cnt_n   = '0;
            idsel_n     = sel_encode(cfg.cfg_idiv);
            fbdsel_n    = sel_encode(cfg.cfg_fbdiv);
            odsel_n     = cfg.cfg_odsel;
        end

        ready_n = (state_n == RUN) || (state_n == FAIL);
        busy_n  = !ready_n;
    end

    // State, counters and all outputs registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RST_PULSE;
            rst_cnt     <= '0;
            timer       <= '0;
            settle_cnt  <= '0;
            retry_cnt   <= '0;
            pll_reset   <= 1'b1;
            clk_ok      <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b1;
            cfg_ready_q <= 1'b0;
            pll_idsel   <= IDSEL_DEF;
            pll_fbdsel  <= FBDSEL_DEF;
            pll_odsel   <= ODSEL_DEF;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            timer       <= timer_n;
            settle_cnt  <= settle_n;
            retry_cnt   <= retry_n;
            pll_reset   <= pll_reset_n;
            clk_ok      <= clk_ok_n;
            err         <= err_n;
            busy        <= busy_n;
            cfg_ready_q <= ready_n;
            pll_idsel   <= idsel_n;
            pll_fbdsel  <= fbdsel_n;
            pll_odsel   <= odsel_n;
        end
    end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench: each stimulus phase queues the output snapshots it should
// produce (with cycle gaps since the previous change); a monitor pops one entry
// per observed output change.
module tb_pll_reconfig_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset, clk_ok, busy, err;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [1:0] retry_cnt;

    pll_reconfig_ctrl_if cfg_bus ();

    pll_reconfig_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (64),
        .SETTLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg_bus),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .clk_ok     (clk_ok),
        .busy       (busy),
        .err        (err),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] vec;
        int          gap;   // cycles since previous change; 0 = not checked
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_evt(input string name, input int gap,
                              input logic r, input logic ok, input logic b,
                              input logic e, input logic rdy, input logic [1:0] rc,
                              input logic [5:0] i, input logic [5:0] f,
                              input logic [5:0] o);
        exp_t x;
        x.vec  = {r, ok, b, e, rdy, rc, i, f, o};
        x.gap  = gap;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic wait_reset(input logic lvl, input string what);
        int n = 0;
        while (pll_reset !== lvl && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (pll_reset !== lvl) begin
            n_bad++;
            $display("FAIL %s: pll_reset=%0b after %0d cycles, required %0b", what, pll_reset, n, lvl);
        end
    endtask

    task automatic wait_clk_ok(input string what);
        int n = 0;
        while (clk_ok !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (clk_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: clk_ok=%0b after %0d cycles, required 1", what, clk_ok, n);
        end
    endtask

    task automatic wait_err(input string what);
        int n = 0;
        while (err !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: err=%0b after %0d cycles, required 1", what, err, n);
        end
    endtask

    // PLL model: lock rises a fixed delay after the reset pulse ends.
    task automatic lock_after(input int dly, input logic glitch);
        wait_reset(1'b1, "pulse_rise");
        wait_reset(1'b0, "pulse_fall");
        repeat (dly) @(negedge clk);
        pll_lock = 1'b1;
        if (glitch) begin
            repeat (6) @(negedge clk);
            pll_lock = 1'b0;
            @(negedge clk);
            pll_lock = 1'b1;
        end
    endtask

    task automatic send_cfg(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_idiv  = i;
        cfg_bus.cfg_fbdiv = f;
        cfg_bus.cfg_odsel = o;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        pll_lock          = 1'b0;
    endtask

    // Monitor: compare every change of the observable output vector.
    initial begin
        logic [24:0] obs, last;
        bit          first = 1'b1;
        int          since = 0;
        exp_t        x;
        last = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            since++;
            obs = {pll_reset, clk_ok, busy, err, cfg_bus.cfg_ready, retry_cnt,
                   pll_idsel, pll_fbdsel, pll_odsel};
            if (first || obs !== last) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got %h, required no change", obs);
                end else begin
                    x = exp_q.pop_front();
                    if (obs !== x.vec) begin
                        n_bad++;
                        $display("FAIL %s: got %h, required %h", x.name, obs, x.vec);
                    end
                    if (x.gap > 0) begin
                        n_cmp++;
                        if (since != x.gap) begin
                            n_bad++;
                            $display("FAIL %s_gap: got %0d cycles, required %0d", x.name, since, x.gap);
                        end
                    end
                end
                last  = obs;
                since = 0;
                first = 1'b0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed phases.
    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_idiv  = '0;
        cfg_bus.cfg_fbdiv = '0;
        cfg_bus.cfg_odsel = '0;

        // Power-up
        expect_evt("reset",     0, 1, 0, 1, 0, 0, 2'd0, 6'd59, 6'd27, 6'h3E);
        expect_evt("pwr_fall",  6, 0, 0, 1, 0, 0, 2'd0, 6'd59, 6'd27, 6'h3E);
        expect_evt("pwr_run",  21, 0, 1, 0, 0, 1, 2'd0, 6'd59, 6'd27, 6'h3E);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lock_after(10, 1'b0);
        wait_clk_ok("pwr_run_wait");

        // Reconfiguration
        expect_evt("cfg1_accept", 1, 1, 0, 1, 0, 0, 2'd0, 6'd60, 6'd43, 6'h3C);
        expect_evt("cfg1_fall",   4, 0, 0, 1, 0, 0, 2'd0, 6'd60, 6'd43, 6'h3C);
        expect_evt("cfg1_run",   21, 0, 1, 0, 0, 1, 2'd0, 6'd60, 6'd43, 6'h3C);
        send_cfg(6'd3, 6'd20, 6'h3C);
        lock_after(10, 1'b0);
        wait_clk_ok("cfg1_run_wait");

        // Lock loss in RUN
        expect_evt("loss_reset", 3, 1, 0, 1, 0, 0, 2'd0, 6'd60, 6'd43, 6'h3C);
        expect_evt("loss_fall",  4, 0, 0, 1, 0, 0, 2'd0, 6'd60, 6'd43, 6'h3C);
        expect_evt("loss_run",  21, 0, 1, 0, 0, 1, 2'd0, 6'd60, 6'd43, 6'h3C);
        pll_lock = 1'b0;
        lock_after(10, 1'b0);
        wait_clk_ok("loss_run_wait");

        // Settle glitch, divider extremes
        expect_evt("cfg2_accept", 1, 1, 0, 1, 0, 0, 2'd0, 6'd63, 6'd0, 6'h00);
        expect_evt("cfg2_fall",   4, 0, 0, 1, 0, 0, 2'd0, 6'd63, 6'd0, 6'h00);
        expect_evt("glitch_run", 28, 0, 1, 0, 0, 1, 2'd0, 6'd63, 6'd0, 6'h00);
        send_cfg(6'd0, 6'd63, 6'h00);
        lock_after(10, 1'b1);
        wait_clk_ok("glitch_run_wait");

        // Timeout, retries, FAIL, cleared by new cfg
        expect_evt("to_accept",  1, 1, 0, 1, 0, 0, 2'd0, 6'd0, 6'd63, 6'h15);
        expect_evt("to_fall0",   4, 0, 0, 1, 0, 0, 2'd0, 6'd0, 6'd63, 6'h15);
        expect_evt("to_retry1", 64, 1, 0, 1, 0, 0, 2'd1, 6'd0, 6'd63, 6'h15);
        expect_evt("to_fall1",   4, 0, 0, 1, 0, 0, 2'd1, 6'd0, 6'd63, 6'h15);
        expect_evt("to_retry2", 64, 1, 0, 1, 0, 0, 2'd2, 6'd0, 6'd63, 6'h15);
        expect_evt("to_fall2",   4, 0, 0, 1, 0, 0, 2'd2, 6'd0, 6'd63, 6'h15);
        expect_evt("to_fail",   64, 1, 0, 0, 1, 1, 2'd2, 6'd0, 6'd63, 6'h15);
        expect_evt("err_clear",  1, 1, 0, 1, 0, 0, 2'd0, 6'd53, 6'd13, 6'h2A);
        expect_evt("clr_fall",   4, 0, 0, 1, 0, 0, 2'd0, 6'd53, 6'd13, 6'h2A);
        send_cfg(6'd63, 6'd0, 6'h15);
        wait_err("to_fail_wait");
        send_cfg(6'd10, 6'd50, 6'h2A);

        // rst mid WAIT_LOCK restores defaults
        expect_evt("rst_mid",   6, 1, 0, 1, 0, 0, 2'd0, 6'd59, 6'd27, 6'h3E);
        expect_evt("rst_fall",  5, 0, 0, 1, 0, 0, 2'd0, 6'd59, 6'd27, 6'h3E);
        expect_evt("rst_run",  21, 0, 1, 0, 0, 1, 2'd0, 6'd59, 6'd27, 6'h3E);
        wait_reset(1'b1, "clr_pulse");
        wait_reset(1'b0, "clr_release");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lock_after(10, 1'b0);
        wait_clk_ok("rst_run_wait");

        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
